// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// neuron_pkg: shared defaults, widths and FSM state encoding for the scheduler
// Revision: 1.0
// ============================================================================
package neuron_pkg;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_N_STAGES  = 5;
  localparam int DEF_INPUTS    = 2 ** DEF_N_STAGES;
  localparam int DEF_U_W       = DEF_N_STAGES + 2;
  localparam int SHIFT_W       = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_scheduler_if.sv
`default_nettype none
// ============================================================================
// neuron_scheduler_if: host-side weight-load, timestep and result signals
// Revision: 1.0
// ============================================================================
interface neuron_scheduler_if #(
  parameter int N_NEURONS = neuron_pkg::DEF_N_NEURONS,
  parameter int N_STAGES  = neuron_pkg::DEF_N_STAGES,
  localparam int INPUTS   = 2 ** N_STAGES,
  localparam int U_W      = N_STAGES + 2
);

  logic                 clr;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [7:0]           cfg_data;
  logic                 step_valid;
  logic                 step_ready;
  logic [INPUTS-1:0]    step_x;
  logic [U_W-1:0]       cfg_minus_teta;
  logic [2:0]           cfg_shift;
  logic                 spike_valid;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 busy;

  modport master (
    output clr, cfg_valid, cfg_data, step_valid, step_x, cfg_minus_teta, cfg_shift,
    input  cfg_ready, step_ready, spike_valid, spike_vec, busy
  );

  modport slave (
    input  clr, cfg_valid, cfg_data, step_valid, step_x, cfg_minus_teta, cfg_shift,
    output cfg_ready, step_ready, spike_valid, spike_vec, busy
  );

endinterface
`default_nettype wire

// File: rtl/neuron_cfg_loader.sv
`default_nettype none
// ============================================================================
// neuron_cfg_loader: byte-serial weight loader, LSB byte / neuron 0 first
// Revision: 1.0
// ============================================================================
module neuron_cfg_loader
  import neuron_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int W_BYTES   = 4,
  localparam int W_W      = 8 * W_BYTES,
  localparam int IDX_W    = idx_width(N_NEURONS),
  localparam int BYTE_W   = idx_width(W_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W_W-1:0]   rd_weight
);

  // Byte counter kept as {word, byte} so non-power-of-two neuron counts wrap cleanly
  logic [BYTE_W-1:0] r_byte;
  logic [IDX_W-1:0]  r_word;
  logic [W_W-1:0]    w_weight [N_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte <= '0;
      r_word <= '0;
    end else if (clr) begin
      r_byte <= '0;
      r_word <= '0;
    end else if (wr_en) begin
      if (r_byte == BYTE_W'(W_BYTES - 1)) begin
        r_byte <= '0;
        r_word <= (r_word == IDX_W'(N_NEURONS - 1)) ? '0 : r_word + IDX_W'(1);
      end else begin
        r_byte <= r_byte + BYTE_W'(1);
      end
    end
  end

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_word
    logic [W_BYTES-1:0][7:0] r_bytes;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_bytes <= '0;
      end else if (wr_en && (r_word == IDX_W'(n))) begin
        r_bytes[r_byte] <= wr_data;
      end
    end

    assign w_weight[n] = r_bytes;
  end

  assign rd_weight = w_weight[rd_idx];

endmodule
`default_nettype wire

// File: rtl/neuron_scheduler.sv
`default_nettype none
// ============================================================================
// neuron_scheduler: time-multiplexes N_NEURONS virtual neurons onto one datapath
// Revision: 1.0
// ============================================================================
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int N_STAGES  = DEF_N_STAGES,
  localparam int INPUTS   = 2 ** N_STAGES,
  localparam int U_W      = N_STAGES + 2,
  localparam int IDX_W    = idx_width(N_NEURONS)
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_scheduler_if.slave  host,
  output logic [INPUTS-1:0]  nrn_w,
  output logic [INPUTS-1:0]  nrn_x,
  output logic [U_W-1:0]     nrn_prev_u,
  output logic [U_W-1:0]     nrn_minus_teta,
  output logic [2:0]         nrn_shift,
  output logic               nrn_was_spike,
  input  logic [U_W-1:0]     nrn_u,
  input  logic               nrn_spike
);

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [INPUTS-1:0]    r_x;
  logic [U_W-1:0]       r_minus_teta;
  logic [2:0]           r_shift;
  logic [U_W-1:0]       r_u_mem [N_NEURONS];
  logic [N_NEURONS-1:0] r_spk_mem;
  logic [N_NEURONS-1:0] r_spike_vec;

  logic              w_idle;
  logic              w_eval;
  logic              w_last;
  logic              w_cfg_fire;
  logic              w_step_fire;
  logic [INPUTS-1:0] w_weight;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_eval      = (r_state == ST_EVAL);
  assign w_last      = (r_idx == IDX_W'(N_NEURONS - 1));
  assign w_cfg_fire  = host.cfg_valid & w_idle;
  assign w_step_fire = host.step_valid & host.step_ready;

  // Weight bytes take priority over a step request presented in the same cycle
  assign host.cfg_ready   = w_idle;
  assign host.step_ready  = w_idle & ~host.cfg_valid & ~host.clr;
  assign host.spike_valid = (r_state == ST_DONE) & ~host.clr;
  assign host.spike_vec   = r_spike_vec;
  assign host.busy        = ~w_idle;

  neuron_cfg_loader #(
    .N_NEURONS (N_NEURONS),
    .W_BYTES   (INPUTS / 8)
  ) u_cfg_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (host.clr),
    .wr_en     (w_cfg_fire),
    .wr_data   (host.cfg_data),
    .rd_idx    (r_idx),
    .rd_weight (w_weight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_x          <= '0;
      r_minus_teta <= '0;
      r_shift      <= '0;
    end else if (host.clr) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_step_fire) begin
            r_x          <= host.step_x;
            r_minus_teta <= host.cfg_minus_teta;
            r_shift      <= host.cfg_shift;
            r_idx        <= '0;
            r_state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (w_last) begin
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Membrane values are stored exactly as the datapath returns them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) r_u_mem[n] <= '0;
      r_spk_mem   <= '0;
      r_spike_vec <= '0;
    end else if (host.clr) begin
      for (int n = 0; n < N_NEURONS; n++) r_u_mem[n] <= '0;
      r_spk_mem   <= '0;
      r_spike_vec <= '0;
    end else if (w_eval) begin
      r_u_mem[r_idx]     <= nrn_u;
      r_spk_mem[r_idx]   <= nrn_spike;
      r_spike_vec[r_idx] <= nrn_spike;
    end
  end

  always_comb begin
    nrn_w          = '0;
    nrn_x          = '0;
    nrn_prev_u     = '0;
    nrn_minus_teta = '0;
    nrn_shift      = '0;
    nrn_was_spike  = 1'b0;
    if (w_eval) begin
      nrn_w          = w_weight;
      nrn_x          = r_x;
      nrn_prev_u     = r_u_mem[r_idx];
      nrn_minus_teta = r_minus_teta;
      nrn_shift      = r_shift;
      nrn_was_spike  = r_spk_mem[r_idx];
    end
  end

endmodule
`default_nettype wire

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of virtual neurons time-multiplexed onto one neuron datapath.
REQ-002 Parameter N_STAGES, default 5: datapath adder stages; INPUTS = 2**N_STAGES; U_W = N_STAGES+2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 clr  in  1  synchronous soft clear of membrane/spike history and abort of any step.
REQ-006 cfg_valid / cfg_ready  in / out  1 / 1  weight-byte handshake.
REQ-007 cfg_data  in  8  weight byte.
REQ-008 step_valid / step_ready  in / out  1 / 1  timestep request handshake.
REQ-009 step_x  in  INPUTS  input spike vector for the timestep.
REQ-010 cfg_minus_teta  in  U_W  negated threshold; cfg_shift  in  3  leak shift; both sampled on step accept.
REQ-011 nrn_w, nrn_x  out  INPUTS  weights and inputs driven to the datapath.
REQ-012 nrn_prev_u, nrn_minus_teta  out  U_W; nrn_shift  out  3; nrn_was_spike  out  1.
REQ-013 nrn_u  in  U_W; nrn_spike  in  1: combinational datapath results.
REQ-014 spike_valid  out  1  one-cycle result strobe; spike_vec  out  N_NEURONS  per-neuron spikes; busy  out  1.

Function
REQ-015 FSM states IDLE, EVAL, DONE; busy=1 exactly when state is not IDLE.
REQ-016 cfg_ready=1 only in IDLE; a cfg transfer writes cfg_data into byte (cnt mod 4) of weight[cnt/4], LSB byte first, neuron 0 first.
REQ-017 Byte counter cnt increments per cfg transfer and wraps from 4*N_NEURONS-1 to 0; partial loads keep untouched bytes.
REQ-018 step_ready = IDLE and not cfg_valid and not clr; cfg has priority over step in the same cycle.
REQ-019 On step accept: latch step_x, cfg_minus_teta, cfg_shift; idx<=0; IDLE->EVAL.
REQ-020 EVAL, one neuron per cycle: drive nrn_w=weight[idx], nrn_x=latched x, nrn_prev_u=u_mem[idx], nrn_was_spike=spk_mem[idx], latched teta/shift.
REQ-021 Each EVAL edge: u_mem[idx]<=nrn_u, spk_mem[idx]<=nrn_spike, spike_vec[idx]<=nrn_spike, idx increments; after idx=N_NEURONS-1 go DONE.
REQ-022 DONE lasts one cycle with spike_valid=1 and spike_vec complete; then IDLE; spike_valid=0 in all other cycles.
REQ-023 Latency: step accepted at edge k -> spike_valid high in cycle k+N_NEURONS+1; step_ready high again in cycle k+N_NEURONS+2.
REQ-024 spike_vec holds its value until the next step's EVAL overwrites it bit by bit.
REQ-025 Outside EVAL, nrn_* outputs are driven to 0.
REQ-026 clr in any state: u_mem, spk_mem, spike_vec, cnt zeroed; state->IDLE; no spike_valid for the aborted step; weights retained.
REQ-027 Controller does no arithmetic on u; U_W values pass unmodified between nrn_u and u_mem.

Reset
REQ-028 rst_n low: state IDLE, weights 0, u_mem 0, spk_mem 0, cnt 0, idx 0, latched x/teta/shift 0.
REQ-029 During and after reset until first edge: spike_valid=0, spike_vec=0, busy=0, all nrn_* outputs 0; cfg_ready=1, step_ready = not cfg_valid and not clr.
REQ-030 Reset asserted mid-EVAL aborts immediately; no spike_valid is issued for that step.

Structure
REQ-031 Shared package neuron_pkg holds N_STAGES, INPUTS, U_W, N_NEURONS defaults and the FSM state type.
REQ-032 One sub-module, neuron_cfg_loader: byte deserializer owning cnt and the weight array, exposing weight[idx].
REQ-033 The neuron datapath remains external; this block connects only through nrn_* ports.

Verification
REQ-034 Load bytes 01,02,03,04 after reset -> first EVAL cycle nrn_w=0x04030201; second nrn_w=0.
REQ-035 Behavioural datapath returning nrn_u=idx+3, nrn_spike=idx[0]; step at edge 10, N=4 -> spike_valid only in cycle 15, spike_vec=4'b1010.
REQ-036 Second step, same model -> nrn_prev_u sequence 3,4,5,6; nrn_was_spike sequence 0,1,0,1.
REQ-037 cfg_valid and step_valid high together in IDLE -> cfg byte accepted, step_ready=0 that cycle, step accepted next cycle.
REQ-038 clr pulse in second EVAL cycle -> IDLE next cycle, no spike_valid, next step sees nrn_prev_u=0 for all neurons, weights unchanged.
REQ-039 17 cfg bytes with N=4 -> cnt wraps; byte 17 overwrites byte 0 of weight[0].
